// File: rtl/cpu_types.sv
// Shared word width and RAM status encoding for the cache/RAM path.
package cpu_types;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

// File: rtl/cache_mem_ctrl_if.sv
// Cache request / RAM bus bundle. slave = memory controller, master = caches plus RAM.
interface cache_mem_ctrl_if;
    import cpu_types::*;

    logic        dREN;
    logic        dWEN;
    word_t       daddr;
    word_t       dstore;
    logic        dwait;
    word_t       dload;

    logic        iREN;
    word_t       iaddr;
    logic        iwait;
    word_t       iload;

    logic        ramREN;
    logic        ramWEN;
    word_t       ramaddr;
    word_t       ramstore;
    word_t       ramload;
    ramstate_t   ramstate;

    logic [15:0] err_cnt;

    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, err_cnt
    );

    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, err_cnt
    );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Memory-side responder: arbitrates dcache/icache word requests onto one RAM port and
// returns load data with a single-cycle wait drop on completion.
module cache_mem_ctrl
    import cpu_types::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter word_t       ERR_WORD   = 32'hBAD1BAD1
) (
    input logic             CLK,
    input logic             RST,
    cache_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        DSERVE,
        ISERVE
    } state_t;

    state_t      state_q;
    state_t      grant_d;
    logic [2:0]  starve_q;
    logic [15:0] err_cnt_q;

    logic        d_req;
    logic        starved;
    logic        ram_done;
    logic        serving_d;
    logic        serving_i;
    word_t       load_word;

    assign d_req     = bus.dREN | bus.dWEN;
    assign starved   = bus.iREN && (starve_q == 3'(STARVE_MAX));
    assign ram_done  = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
    // A served requester that drops its enables aborts: everything keys off these.
    assign serving_d = (state_q == DSERVE) && d_req;
    assign serving_i = (state_q == ISERVE) && bus.iREN;
    assign load_word = (bus.ramstate == ERROR) ? ERR_WORD : bus.ramload;

    always_comb begin
        grant_d = IDLE;
        if (d_req && !starved) begin
            grant_d = DSERVE;
        end else if (bus.iREN) begin
            grant_d = ISERVE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE:    state_q <= grant_d;
                DSERVE:  if (!serving_d || ram_done) state_q <= IDLE;
                ISERVE:  if (!serving_i || ram_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (!bus.iREN) begin
                starve_q <= '0;
            end else if (state_q == IDLE && grant_d == DSERVE) begin
                starve_q <= starve_q + 3'd1;
            end else if (state_q == IDLE && grant_d == ISERVE) begin
                starve_q <= '0;
            end

            if ((serving_d || serving_i) && bus.ramstate == ERROR && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // FREE while serving simply falls through as "not done", i.e. behaves like BUSY.
    always_comb begin
        bus.dwait    = 1'b1;
        bus.iwait    = 1'b1;
        bus.dload    = '0;
        bus.iload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        if (serving_d) begin
            bus.ramaddr = bus.daddr;
            if (bus.dWEN) begin
                bus.ramWEN   = 1'b1;
                bus.ramstore = bus.dstore;
            end else begin
                bus.ramREN = 1'b1;
            end
            if (ram_done) begin
                bus.dwait = 1'b0;
                bus.dload = load_word;
            end
        end
        if (serving_i) begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr;
            if (ram_done) begin
                bus.iwait = 1'b0;
                bus.iload = load_word;
            end
        end
    end

    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level ownership model with a word-addressed RAM model.
module tb_cache_mem_ctrl;
    import cpu_types::*;

    localparam word_t ERR = 32'hBAD1BAD1;
    localparam int    SMAX = 4;

    typedef enum int {NOBODY, DCACHE, ICACHE} who_t;

    logic  CLK = 1'b0;
    logic  RST = 1'b1;
    int    total = 0;
    int    bad = 0;

    who_t  owner = NOBODY;
    int    d_run = 0;
    int    errs = 0;
    word_t mem [word_t];

    logic  s_dwait, s_iwait, s_ren;
    word_t s_dload;

    cache_mem_ctrl_if bus ();

    cache_mem_ctrl #(
        .STARVE_MAX(SMAX),
        .ERR_WORD  (ERR)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic word_t mem_rd(input word_t a);
        if (mem.exists(a)) return mem[a];
        return (a ^ 32'hA5A5_0000) + 32'h0001_3579;
    endfunction

    // One clock of traffic; entered and left at posedge+1 with inputs already applied.
    task automatic tick();
        logic  dreq, fin, err, d_fin, i_fin;
        logic  e_dw, e_iw, e_ren, e_wen;
        word_t e_dl, e_il, e_addr, e_st;
        who_t  owner_n;
        #1 bus.ramload = mem_rd(bus.ramaddr);
        #2;
        dreq  = bus.dREN | bus.dWEN;
        fin   = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
        err   = (bus.ramstate == ERROR);
        e_dw  = 1'b1; e_iw = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
        e_dl  = '0;   e_il = '0;   e_addr = '0;  e_st = '0;
        d_fin = 1'b0; i_fin = 1'b0;
        if (owner == DCACHE && dreq) begin
            e_addr = bus.daddr;
            e_wen  = bus.dWEN;
            e_ren  = !bus.dWEN;
            if (bus.dWEN) e_st = bus.dstore;
            if (fin) begin
                d_fin = 1'b1;
                e_dw  = 1'b0;
                e_dl  = err ? ERR : mem_rd(bus.daddr);
            end
        end
        if (owner == ICACHE && bus.iREN) begin
            e_addr = bus.iaddr;
            e_ren  = 1'b1;
            if (fin) begin
                i_fin = 1'b1;
                e_iw  = 1'b0;
                e_il  = err ? ERR : mem_rd(bus.iaddr);
            end
        end
        s_dwait = bus.dwait;
        s_iwait = bus.iwait;
        s_ren   = bus.ramREN;
        s_dload = bus.dload;
        check("dwait",    32'(bus.dwait),   32'(e_dw));
        check("iwait",    32'(bus.iwait),   32'(e_iw));
        check("dload",    bus.dload,        e_dl);
        check("iload",    bus.iload,        e_il);
        check("ramREN",   32'(bus.ramREN),  32'(e_ren));
        check("ramWEN",   32'(bus.ramWEN),  32'(e_wen));
        check("ramaddr",  bus.ramaddr,      e_addr);
        check("ramstore", bus.ramstore,     e_st);
        check("err_cnt",  32'(bus.err_cnt), 32'(errs));

        if (d_fin || i_fin) begin
            $display("txn %s %s addr=%h load=%h%s", d_fin ? "dcache" : "icache",
                     (d_fin && bus.dWEN) ? "wr" : "rd", e_addr, d_fin ? e_dl : e_il,
                     err ? " error" : "");
            if (err && errs < 16'hFFFF) errs++;
            if (d_fin && bus.dWEN && !err) mem[bus.daddr] = bus.dstore;
        end

        owner_n = owner;
        if (owner == NOBODY) begin
            if (dreq && !(bus.iREN && d_run == SMAX)) owner_n = DCACHE;
            else if (bus.iREN)                          owner_n = ICACHE;
        end else if (d_fin || i_fin || (owner == DCACHE && !dreq) || (owner == ICACHE && !bus.iREN)) begin
            owner_n = NOBODY;
        end
        if (!bus.iREN)                                   d_run = 0;
        else if (owner == NOBODY && owner_n == DCACHE)   d_run++;
        else if (owner == NOBODY && owner_n == ICACHE)   d_run = 0;

        @(posedge CLK);
        #1 owner = owner_n;
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1;
        #2;
        check({tag, "_dwait"},    32'(bus.dwait),   32'd1);
        check({tag, "_iwait"},    32'(bus.iwait),   32'd1);
        check({tag, "_dload"},    bus.dload,        32'd0);
        check({tag, "_iload"},    bus.iload,        32'd0);
        check({tag, "_ramREN"},   32'(bus.ramREN),  32'd0);
        check({tag, "_ramWEN"},   32'(bus.ramWEN),  32'd0);
        check({tag, "_ramaddr"},  bus.ramaddr,      32'd0);
        check({tag, "_ramstore"}, bus.ramstore,     32'd0);
        check({tag, "_err_cnt"},  32'(bus.err_cnt), 32'd0);
        owner = NOBODY;
        d_run = 0;
        errs  = 0;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // Single dcache access: arbitration cycle, nbusy BUSY cycles, then the final RAM status.
    task automatic d_access(input logic wen, input word_t addr, input word_t data, input int nbusy,
                            input ramstate_t last, output int lat, output word_t load);
        bus.dREN   = !wen;
        bus.dWEN   = wen;
        bus.daddr  = addr;
        bus.dstore = data;
        lat  = -1;
        load = '0;
        for (int c = 0; c < nbusy + 2; c++) begin
            bus.ramstate = (c == nbusy + 1) ? last : BUSY;
            tick();
            if (!s_dwait && lat < 0) begin
                lat  = c;
                load = s_dload;
            end
        end
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    initial begin
        int    lat;
        word_t load;
        byte   seq [$];
        logic  d_busy, i_busy;
        int    r;

        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        bus.iREN = 1'b0; bus.iaddr = '0;  bus.ramload = '0; bus.ramstate = FREE;

        do_reset("rst");

        mem[32'h100] = 32'hDEADBEEF;
        d_access(1'b0, 32'h100, '0, 2, ACCESS, lat, load);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_load", load, 32'hDEADBEEF);
        tick();

        d_access(1'b1, 32'h3100, 32'h5, 3, ACCESS, lat, load);
        check("wr_latency", 32'(lat), 32'd4);
        tick();
        d_access(1'b0, 32'h3100, '0, 0, ACCESS, lat, load);
        check("wr_readback", load, 32'h5);
        tick();

        d_access(1'b0, 32'h40, '0, 1, ERROR, lat, load);
        check("err_latency", 32'(lat), 32'd2);
        check("err_load", load, ERR);
        tick();
        check("err_cnt_one", 32'(bus.err_cnt), 32'd1);

        bus.dREN = 1'b1; bus.daddr = 32'h200; bus.ramstate = BUSY;
        tick();
        tick();
        bus.dREN = 1'b0;
        tick();
        check("abort_ramREN", 32'(s_ren), 32'd0);
        check("abort_dwait", 32'(s_dwait), 32'd1);
        bus.dREN = 1'b1; bus.ramstate = ACCESS;
        tick();
        check("abort_idle", 32'(s_dwait), 32'd1);
        tick();
        check("abort_retry", 32'(s_dwait), 32'd0);
        bus.dREN = 1'b0;
        tick();

        // Both caches hammering with instant RAM: icache gets every fifth grant.
        bus.dREN = 1'b1; bus.daddr = 32'h10; bus.iREN = 1'b1; bus.iaddr = 32'h20;
        bus.ramstate = ACCESS;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!s_dwait) seq.push_back("D");
            if (!s_iwait) seq.push_back("I");
        end
        bus.dREN = 1'b0; bus.iREN = 1'b0;
        tick();
        check("starve_count", 32'(seq.size()), 32'd10);
        for (int k = 0; k < seq.size(); k++) begin
            check($sformatf("starve_grant%0d", k), 32'(seq[k]), ((k % 5) == 4) ? 32'("I") : 32'("D"));
        end

        bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramstate = BUSY;
        tick();
        tick();
        do_reset("midrst");
        d_access(1'b0, 32'h80, '0, 1, ACCESS, lat, load);
        check("post_rst_latency", 32'(lat), 32'd2);
        check("post_rst_load", load, mem_rd(32'h80));
        tick();

        d_busy = 1'b0;
        i_busy = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!d_busy) begin
                if ($urandom_range(0, 2) == 0) begin
                    r = int'($urandom_range(0, 2));
                    d_busy     = 1'b1;
                    bus.dREN   = (r != 1);
                    bus.dWEN   = (r != 0);
                    bus.daddr  = 32'($urandom_range(0, 15));
                    bus.dstore = $urandom;
                end
            end else if ($urandom_range(0, 29) == 0) begin
                d_busy   = 1'b0;
                bus.dREN = 1'b0;
                bus.dWEN = 1'b0;
            end
            if (!i_busy) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_busy    = 1'b1;
                    bus.iREN  = 1'b1;
                    bus.iaddr = 32'($urandom_range(0, 15));
                end
            end else if ($urandom_range(0, 39) == 0) begin
                i_busy   = 1'b0;
                bus.iREN = 1'b0;
            end
            r = int'($urandom_range(0, 19));
            if (r < 3)       bus.ramstate = FREE;
            else if (r < 9)  bus.ramstate = BUSY;
            else if (r < 17) bus.ramstate = ACCESS;
            else             bus.ramstate = ERROR;
            tick();
            if (!s_dwait) begin
                d_busy   = 1'b0;
                bus.dREN = 1'b0;
                bus.dWEN = 1'b0;
            end
            if (!s_iwait) begin
                i_busy   = 1'b0;
                bus.iREN = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
